// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART core.
package uart_pkg;

  // Oversampling ticks per bit; the core is built around 16x.
  localparam int SB_TICK_DEFAULT = 16;

  // Parity mode encodings (00 and 11 both mean "no parity").
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BRK    = 3'd5
  } rx_state_e;

  // True when the mode carries a parity bit in the frame.
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [AW:0]   wptr_q, rptr_q;
  logic [DW-1:0] mem_q [2**AW];
  logic          wr_en, rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A write into a full FIFO is allowed only when a read frees a slot this cycle.
  assign wr_en = wr && (!full || rd);
  // Reading an empty FIFO does nothing, even if a write lands the same cycle.
  assign rd_en = rd && !empty;
  assign dout  = mem_q[rptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_core_fifo.sv
// UART core: runtime-divisor baud generator, TX and RX engines with optional
// parity and 1/2 stop bits, TX/RX FIFOs and sticky error flags.
// Handshake: tx_wr pushes tx_din when asserted (dropped if tx_full); rx_rd pops
// the RX head when asserted (ignored if rx_empty); rx_dout is valid whenever
// !rx_empty. Both are single-cycle strobes sampled on the rising clock edge.
module uart_core_fifo
  import uart_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = SB_TICK_DEFAULT,
  parameter int DIV_BITS = 11,
  parameter int FIFO_AW  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIV_BITS-1:0] divisor,
  input  logic [1:0]          parity_mode,
  input  logic                two_stop,
  input  logic                tx_wr,
  input  logic [DBIT-1:0]     tx_din,
  output logic                tx_full,
  output logic                tx_empty,
  output logic                tx_busy,
  output logic                tx,
  input  logic                rx,
  input  logic                rx_rd,
  output logic [DBIT-1:0]     rx_dout,
  output logic                rx_empty,
  output logic                rx_full,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun_err,
  input  logic                err_clr,
  output logic [2:0]          tx_state_dbg,
  output logic [2:0]          rx_state_dbg
);

  localparam logic [4:0] LAST_TICK = 5'(SB_TICK - 1);
  localparam logic [4:0] LAST_TICK2 = 5'(2 * SB_TICK - 1);
  localparam logic [4:0] MID_TICK  = 5'(SB_TICK / 2 - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DBIT - 1);

  // ---------------- baud generator ----------------
  logic [DIV_BITS-1:0] baud_cnt_q, div_q;
  logic                s_tick;

  assign s_tick = (baud_cnt_q == div_q);

  // Count 0..div_q; the divisor is re-latched at each wrap so changes land cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt_q <= '0;
      div_q      <= '0;
    end else if (s_tick) begin
      baud_cnt_q <= '0;
      div_q      <= divisor;
    end else begin
      baud_cnt_q <= baud_cnt_q + 1'b1;
    end
  end

  // ---------------- TX path ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [4:0]      tx_tick_q, tx_tick_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [DBIT-1:0] tx_shift_q, tx_shift_d;
  logic            tx_par_q, tx_par_d;
  logic [1:0]      tx_mode_q, tx_mode_d;
  logic            tx_two_q, tx_two_d;
  logic            tx_q, tx_d;
  logic            tx_pop, tx_load;
  logic [DBIT-1:0] tx_head;

  uart_sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .din   (tx_din),
    .rd    (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // TX state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_mode_q  <= 2'b00;
      tx_two_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_mode_q  <= tx_mode_d;
      tx_two_q   <= tx_two_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state; a frame load (from IDLE or end of STOP) pops the FIFO and
  // latches the frame configuration so mid-frame config changes are ignored.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_mode_d  = tx_mode_q;
    tx_two_d   = tx_two_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) tx_load = 1'b1;
      end
      TX_START: begin
        if (s_tick) begin
          if (tx_tick_q == LAST_TICK) begin
            tx_tick_d  = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
            tx_d       = tx_shift_q[0];
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (s_tick) begin
          if (tx_tick_q == LAST_TICK) begin
            tx_tick_d  = '0;
            tx_shift_d = {1'b0, tx_shift_q[DBIT-1:1]};
            if (tx_bit_q == LAST_BIT) begin
              if (has_parity(tx_mode_q)) begin
                tx_state_d = TX_PARITY;
                tx_d       = tx_par_q;
              end else begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
              end
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
              tx_d     = tx_shift_q[1];
            end
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (s_tick) begin
          if (tx_tick_q == LAST_TICK) begin
            tx_tick_d  = '0;
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (s_tick) begin
          if (tx_tick_q == (tx_two_q ? LAST_TICK2 : LAST_TICK)) begin
            if (!tx_empty) begin
              tx_load = 1'b1;
            end else begin
              tx_state_d = TX_IDLE;
              tx_d       = 1'b1;
            end
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_state_d = TX_START;
      tx_tick_d  = '0;
      tx_shift_d = tx_head;
      tx_par_d   = (parity_mode == PAR_ODD) ? ~^tx_head : ^tx_head;
      tx_mode_d  = parity_mode;
      tx_two_d   = two_stop;
      tx_d       = 1'b0;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (tx_state_q != TX_IDLE);
  assign tx_state_dbg = tx_state_q;

  // ---------------- RX path ----------------
  rx_state_e       rx_state_q, rx_state_d;
  logic [4:0]      rx_tick_q, rx_tick_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [DBIT-1:0] rx_shift_q, rx_shift_d;
  logic            rx_par_q, rx_par_d;
  logic [1:0]      rx_mode_q, rx_mode_d;
  logic            rx_meta_q, rx_s_q;
  logic            rx_push, pe_set, fe_set, ov_set, rx_par_exp;
  logic            pe_q, fe_q, ov_q;

  uart_sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_push),
    .din   (rx_shift_q),
    .rd    (rx_rd),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // RX state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_mode_q  <= 2'b00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_mode_q  <= rx_mode_d;
    end
  end

  assign rx_par_exp = (rx_mode_q == PAR_ODD) ? ~^rx_shift_q : ^rx_shift_q;

  // RX next state: mid-start recheck rejects glitches, then every bit is
  // sampled at its centre; the stop sample decides push / error.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_mode_d  = rx_mode_q;
    rx_push    = 1'b0;
    pe_set     = 1'b0;
    fe_set     = 1'b0;
    ov_set     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
          rx_mode_d  = parity_mode;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (rx_tick_q == MID_TICK) begin
            if (rx_s_q) begin
              rx_state_d = RX_IDLE;
            end else begin
              rx_state_d = RX_DATA;
              rx_tick_d  = '0;
              rx_bit_d   = '0;
            end
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (rx_tick_q == LAST_TICK) begin
            rx_tick_d  = '0;
            rx_shift_d = {rx_s_q, rx_shift_q[DBIT-1:1]};
            if (rx_bit_q == LAST_BIT) begin
              rx_state_d = has_parity(rx_mode_q) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (s_tick) begin
          if (rx_tick_q == LAST_TICK) begin
            rx_tick_d  = '0;
            rx_par_d   = rx_s_q;
            rx_state_d = RX_STOP;
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (s_tick) begin
          if (rx_tick_q == LAST_TICK) begin
            rx_tick_d = '0;
            if (!rx_s_q) begin
              fe_set     = 1'b1;
              rx_state_d = RX_BRK;
            end else begin
              rx_state_d = RX_IDLE;
              if (has_parity(rx_mode_q) && (rx_par_q != rx_par_exp)) pe_set = 1'b1;
              else if (rx_full)                                     ov_set = 1'b1;
              else                                                  rx_push = 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        end
      end
      RX_BRK: begin
        if (rx_s_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_state_dbg = rx_state_q;

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      pe_q <= pe_set | (pe_q & ~err_clr);
      fe_q <= fe_set | (fe_q & ~err_clr);
      ov_q <= ov_set | (ov_q & ~err_clr);
    end
  end

  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign overrun_err = ov_q;

endmodule

// File: tb/tb_uart_core_fifo.sv
// Directed bench for uart_core_fifo at divisor=3 (4 clk per tick, 64 clk per bit).
module tb_uart_core_fifo;

  localparam int DBIT = 8;
  localparam int BIT_CLK = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [10:0]     divisor = 11'd3;
  logic [1:0]      parity_mode = 2'b00;
  logic            two_stop = 1'b0;
  logic            tx_wr = 1'b0;
  logic [DBIT-1:0] tx_din = '0;
  logic            rx_rd = 1'b0;
  logic            err_clr = 1'b0;
  logic            rx_drv = 1'b1;
  logic            loop_en = 1'b0;
  logic            rx_w;
  logic            tx_full, tx_empty, tx_busy, tx_w;
  logic [DBIT-1:0] rx_dout;
  logic            rx_empty, rx_full, parity_err, frame_err, overrun_err;
  logic [2:0]      tx_state_dbg, rx_state_dbg;

  assign rx_w = loop_en ? tx_w : rx_drv;

  uart_core_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .divisor      (divisor),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .tx_wr        (tx_wr),
    .tx_din       (tx_din),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_busy      (tx_busy),
    .tx           (tx_w),
    .rx           (rx_w),
    .rx_rd        (rx_rd),
    .rx_dout      (rx_dout),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .err_clr      (err_clr),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DBIT-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [DBIT-1:0] d);
    tx_din = d;
    tx_wr  = 1'b1;
    @(negedge clk);
    tx_wr  = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Drives one 8-bit frame on rx, then one idle bit time.
  task automatic send_rx_frame(input logic [7:0] d, input logic use_par,
                               input logic par_bit, input logic stop_bit);
    rx_drv = 1'b0;
    clks(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      clks(BIT_CLK);
    end
    if (use_par) begin
      rx_drv = par_bit;
      clks(BIT_CLK);
    end
    rx_drv = stop_bit;
    clks(BIT_CLK);
    rx_drv = 1'b1;
    clks(BIT_CLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [7:0] a5;
    int n;
    a5 = 8'hA5;

    clks(3);
    check("rst_tx", tx_w, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_rx_full", rx_full, 0);
    check("rst_errs", {parity_err, frame_err, overrun_err}, 0);
    reset = 1'b0;
    clks(10);

    // TX 0xA5, no parity, one stop: 2-clk start latency then LSB-first bits.
    write_tx(8'hA5);
    check("tx_lat1_tx", tx_w, 1);
    check("tx_lat1_empty", tx_empty, 0);
    @(negedge clk);
    check("tx_lat2_tx", tx_w, 0);
    check("tx_lat2_busy", tx_busy, 1);
    check("tx_lat2_empty", tx_empty, 1);
    clks(96);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_a5_bit%0d", i), tx_w, a5[i]);
      clks(BIT_CLK);
    end
    check("tx_a5_stop", tx_w, 1);
    n = 0;
    while (tx_busy && n < 200) begin @(negedge clk); n++; end
    check("tx_idle_timeout", n < 200, 1);
    check("tx_idle_line", tx_w, 1);

    // Even parity loopback of 0x07: parity bit 1.
    parity_mode = 2'b01;
    loop_en = 1'b1;
    write_tx(8'h07);
    @(negedge clk);
    check("tx07_start", tx_w, 0);
    clks(96 + 8 * BIT_CLK);
    check("tx07_parity_bit", tx_w, 1);
    n = 0;
    while (rx_empty && n < 2000) begin @(negedge clk); n++; end
    check("loop_rx_timeout", n < 2000, 1);
    check("loop_rx_dout", rx_dout, 8'h07);
    check("loop_errs", {parity_err, frame_err, overrun_err}, 0);
    pop_rx();
    check("loop_rx_empty", rx_empty, 1);
    clks(200);
    loop_en = 1'b0;

    // Framing error: stop bit low.
    parity_mode = 2'b00;
    send_rx_frame(8'h55, 1'b0, 1'b0, 1'b0);
    check("fe_flag", frame_err, 1);
    check("fe_rx_empty", rx_empty, 1);
    check("fe_parity_err", parity_err, 0);
    clear_errs();
    check("fe_cleared", frame_err, 0);

    // Odd parity: wrong parity bit on 0x3C (correct is 1), then a good frame.
    parity_mode = 2'b10;
    send_rx_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    check("pe_flag", parity_err, 1);
    check("pe_rx_empty", rx_empty, 1);
    check("pe_frame_err", frame_err, 0);
    clear_errs();
    check("pe_cleared", parity_err, 0);
    send_rx_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check("odd_good_empty", rx_empty, 0);
    check("odd_good_dout", rx_dout, 8'h3C);
    check("odd_good_pe", parity_err, 0);
    pop_rx();

    // Overrun: 17 frames 0x00..0x10 into a 16-deep FIFO.
    parity_mode = 2'b00;
    for (int i = 0; i < 17; i++) begin
      send_rx_frame(8'(i), 1'b0, 1'b0, 1'b1);
      if (i < 16) exp_q.push_back(8'(i));
      if (i == 15) begin
        check("ovr_full16", rx_full, 1);
        check("ovr_none16", overrun_err, 0);
      end
    end
    check("ovr_flag", overrun_err, 1);
    check("ovr_full", rx_full, 1);
    check("ovr_head", rx_dout, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), rx_dout, exp_q.pop_front());
      pop_rx();
    end
    check("drain_empty", rx_empty, 1);
    check("drain_not_full", rx_full, 0);
    clear_errs();
    check("ovr_cleared", overrun_err, 0);

    // Glitches shorter than half a bit are rejected.
    rx_drv = 1'b0; clks(8);  rx_drv = 1'b1; clks(100);
    rx_drv = 1'b0; clks(20); rx_drv = 1'b1; clks(800);
    check("glitch_rx_empty", rx_empty, 1);
    check("glitch_errs", {parity_err, frame_err, overrun_err}, 0);

    // Reset mid-frame aborts TX immediately.
    write_tx(8'h00);
    clks(100);
    check("midrst_busy_before", tx_busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_tx", tx_w, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_empty", tx_empty, 1);
    @(negedge clk);
    reset = 1'b0;
    clks(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
